// File: rtl/uart_sync_fifo_pkg.sv
// Shared UART FIFO package: default geometry, depth helper and the
// per-cycle control decode record used by the FIFO top.
package uart_sync_fifo_pkg;

    localparam int unsigned UART_DATA_WIDTH    = 8;
    localparam int unsigned UART_ADDR_BITS     = 4;
    localparam int unsigned UART_ADDR_BITS_MIN = 2;
    localparam int unsigned UART_ADDR_BITS_MAX = 10;

    // Number of entries for a given pointer width.
    function automatic int unsigned fifo_depth(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

    // Decoded outcome of the request inputs for the current cycle.
    typedef struct packed {
        logic rd_ok;        // read accepted, storage read port fires
        logic wr_ok;        // write stored
        logic drop_oldest;  // overwrite-on-full: oldest entry discarded
        logic ovf_evt;      // write found the FIFO full
        logic udf_evt;      // read found the FIFO empty
    } fifo_ctl_t;

endpackage : uart_sync_fifo_pkg

// File: rtl/uart_fifo_ram.sv
// Storage array for the UART FIFO: one synchronous write port and one
// registered read port. The array itself is not reset; only the read
// data register is, so the FIFO output starts at zero.
//   clock, reset_n      : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr       : read request; rd_data updates one clock later
//   rd_data             : registered read data, holds when rd_en is low
module uart_fifo_ram
    import uart_sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned ADDR_BITS  = UART_ADDR_BITS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_BITS);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; storage deliberately has no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; same-address write in the same cycle returns old data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : uart_fifo_ram

// File: rtl/uart_sync_fifo.sv
// Parametrised synchronous FIFO between the UART engines and host logic.
// Selectable full policy (drop new / overwrite oldest), programmable
// almost-full/almost-empty thresholds, occupancy count, registered
// read-valid strobe, sticky overflow/underflow and synchronous flush.
//   clock, reset_n          : clock, async active-low reset
//   write_flag, data_in     : write request and data
//   read_flag               : read request; data_out/data_valid one clock later
//   flush                   : empty the FIFO (same-cycle read/write ignored)
//   clear_errors            : clear sticky flags (a same-cycle error wins)
//   data_out, data_valid    : registered read data and one-cycle strobe
//   empty_flag, full_flag, almost_empty, almost_full : occupancy flags
//   level                   : occupancy 0..2^ADDR_BITS
//   overflow, underflow     : sticky error flags
module uart_sync_fifo
    import uart_sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned ADDR_BITS  = UART_ADDR_BITS,
    parameter bit          OVERWRITE  = 1'b0,
    parameter int unsigned AF_LEVEL   = fifo_depth(ADDR_BITS) - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_flag,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_flag,
    input  logic                  flush,
    input  logic                  clear_errors,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  empty_flag,
    output logic                  full_flag,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_BITS:0]    level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_BITS);
    localparam int unsigned LW    = ADDR_BITS + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [LW-1:0]        level_next;
    logic                 is_full;
    logic                 is_empty;
    fifo_ctl_t            ctl;

    assign is_full  = (level == DEPTH_L);
    assign is_empty = (level == '0);

    // Decode requests against current occupancy; flush suppresses everything.
    always_comb begin
        ctl = '0;
        if (!flush) begin
            ctl.rd_ok   = read_flag && !is_empty;
            ctl.udf_evt = read_flag && is_empty;
            if (write_flag) begin
                // A simultaneous read frees the slot, so full+read+write is not an overflow.
                if (!is_full || ctl.rd_ok) begin
                    ctl.wr_ok = 1'b1;
                end else begin
                    ctl.ovf_evt = 1'b1;
                    if (OVERWRITE) begin
                        ctl.wr_ok       = 1'b1;
                        ctl.drop_oldest = 1'b1;
                    end
                end
            end
        end
    end

    // Occupancy for the next cycle; overwrite-on-full keeps level constant.
    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (ctl.wr_ok && !ctl.rd_ok && !ctl.drop_oldest) begin
            level_next = level + LW'(1);
        end else if (ctl.rd_ok && !ctl.wr_ok) begin
            level_next = level - LW'(1);
        end
    end

    // Pointers wrap naturally modulo depth.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (ctl.wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (ctl.rd_ok || ctl.drop_oldest) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
        end
    end

    // Level and flags; flags are registered from the next level so they track level exactly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level        <= '0;
            empty_flag   <= 1'b1;
            full_flag    <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_L == '0);
        end else begin
            level        <= level_next;
            empty_flag   <= (level_next == '0);
            full_flag    <= (level_next == DEPTH_L);
            almost_empty <= (level_next <= AE_L);
            almost_full  <= (level_next >= AF_L);
        end
    end

    // Read strobe and sticky errors; an error event beats a coincident clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= ctl.rd_ok;
            overflow   <= (overflow  && !clear_errors) || ctl.ovf_evt;
            underflow  <= (underflow && !clear_errors) || ctl.udf_evt;
        end
    end

    uart_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (ctl.wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (ctl.rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule : uart_sync_fifo

// File: tb/tb_uart_sync_fifo.sv
// Directed bench for uart_sync_fifo: a drop-new instance (a) and an
// overwrite-oldest instance (b) share stimulus; expected values are
// hand-derived from the FIFO behaviour.
module tb_uart_sync_fifo;

    logic       clock;
    logic       reset_n;
    logic       write_flag;
    logic [7:0] data_in;
    logic       read_flag;
    logic       flush;
    logic       clear_errors;

    logic [7:0] data_a, data_b;
    logic       dv_a, dv_b, empty_a, empty_b, full_a, full_b;
    logic       ae_a, ae_b, af_a, af_b, ovf_a, ovf_b, udf_a, udf_b;
    logic [4:0] level_a, level_b;

    int unsigned errors = 0;
    int unsigned checks = 0;

    uart_sync_fifo #(.OVERWRITE(1'b0)) dut_a (
        .clock(clock), .reset_n(reset_n), .write_flag(write_flag), .data_in(data_in),
        .read_flag(read_flag), .flush(flush), .clear_errors(clear_errors),
        .data_out(data_a), .data_valid(dv_a), .empty_flag(empty_a), .full_flag(full_a),
        .almost_empty(ae_a), .almost_full(af_a), .level(level_a),
        .overflow(ovf_a), .underflow(udf_a)
    );

    uart_sync_fifo #(.OVERWRITE(1'b1)) dut_b (
        .clock(clock), .reset_n(reset_n), .write_flag(write_flag), .data_in(data_in),
        .read_flag(read_flag), .flush(flush), .clear_errors(clear_errors),
        .data_out(data_b), .data_valid(dv_b), .empty_flag(empty_b), .full_flag(full_b),
        .almost_empty(ae_b), .almost_full(af_b), .level(level_b),
        .overflow(ovf_b), .underflow(udf_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given request inputs; outputs sampled 1 ns after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic f, input logic c);
        write_flag   = w;
        data_in      = d;
        read_flag    = r;
        flush        = f;
        clear_errors = c;
        @(posedge clock);
        #1;
        write_flag   = 1'b0;
        read_flag    = 1'b0;
        flush        = 1'b0;
        clear_errors = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        write_flag   = 1'b0;
        data_in      = 8'h00;
        read_flag    = 1'b0;
        flush        = 1'b0;
        clear_errors = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // Reset state
        check("rst_level_a", level_a, 0);
        check("rst_empty_a", empty_a, 1);
        check("rst_ae_a", ae_a, 1);
        check("rst_full_a", full_a, 0);
        check("rst_af_a", af_a, 0);
        check("rst_dv_a", dv_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_udf_a", udf_a, 0);
        check("rst_level_b", level_b, 0);
        check("rst_empty_b", empty_b, 1);
        check("rst_err_b", {ovf_b, udf_b, dv_b, full_b, af_b}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic ordering: 0x11..0x14 in, read back in order
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        check("basic_level4", level_a, 4);
        check("basic_ae_at4", ae_a, 0);
        check("basic_empty_at4", empty_a, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("basic_rd_data", data_a, 32'(8'h11 + i));
            check("basic_rd_dv", dv_a, 1);
            check("basic_rd_level", level_a, 32'(3 - i));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("basic_dv_drop", dv_a, 0);
        check("basic_empty_end", empty_a, 1);
        check("basic_data_hold", data_a, 8'h14);

        // Full policy: 17 writes
        for (int k = 0; k < 17; k++) begin
            step(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
            if (k == 15) begin
                check("fill_full_a", full_a, 1);
                check("fill_full_b", full_b, 1);
                check("fill_ovf_a_pre", ovf_a, 0);
                check("fill_af_a", af_a, 1);
            end
        end
        check("drop_ovf_a", ovf_a, 1);
        check("drop_level_a", level_a, 16);
        check("ovw_ovf_b", ovf_b, 1);
        check("ovw_level_b", level_b, 16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("drop_rd_a", data_a, 32'(i));
            check("ovw_rd_b", data_b, 32'(i + 1));
        end
        check("drain_empty_a", empty_a, 1);
        check("drain_ovf_sticky", ovf_a, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_ovf_a", ovf_a, 0);
        check("clr_ovf_b", ovf_b, 0);

        // 18 writes: overwrite instance keeps the newest 16
        for (int k = 0; k < 18; k++) step(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
        check("ovw18_level_b", level_b, 16);
        check("ovw18_ovf_b", ovf_b, 1);
        check("drop18_level_a", level_a, 16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("ovw18_rd_b", data_b, 32'(i + 2));
            check("drop18_rd_a", data_a, 32'(i));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Empty read+write: read fails, write lands, no fall-through
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        check("erw_udf", udf_a, 1);
        check("erw_dv", dv_a, 0);
        check("erw_level", level_a, 1);
        check("erw_data_hold", data_a, 8'h0F);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("erw_rd_data", data_a, 8'hA5);
        check("erw_rd_dv", dv_a, 1);
        check("erw_rd_level", level_a, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("erw_clr_udf", udf_a, 0);

        // Full read+write for 20 cycles across pointer wrap
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
            check("frw_data", data_a, (i < 16) ? 32'(8'h20 + i) : 32'(8'h40 + i - 16));
            check("frw_level", level_a, 16);
            check("frw_ovf_a", ovf_a, 0);
            check("frw_ovf_b", ovf_b, 0);
        end
        check("frw_data_b", data_b, 8'h43);

        // Flush with coincident read/write: both ignored, data_out holds
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        check("flush_level", level_a, 0);
        check("flush_empty", empty_a, 1);
        check("flush_dv", dv_a, 0);
        check("flush_data_hold", data_a, 8'h43);
        check("flush_udf", udf_a, 0);

        // Thresholds
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
            if (i == 1) check("thr_ae_at2", ae_a, 1);
            if (i == 2) check("thr_ae_at3", ae_a, 0);
            if (i == 12) check("thr_af_at13", af_a, 0);
        end
        check("thr_af_at14", af_a, 1);
        check("thr_af_b_at14", af_b, 1);
        check("thr_full_at14", full_a, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("thr_flush_level", level_a, 0);
        check("thr_flush_empty", empty_a, 1);
        check("thr_flush_af", af_a, 0);

        // Clear coincident with an underflow event: event wins
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("clr_coinc_udf", udf_a, 1);
        check("clr_coinc_udf_b", udf_b, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_next_udf", udf_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_sync_fifo

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Parametrised synchronous FIFO for the UART datapath, replacing the fixed 8-bit buffer between the UART RX/TX engines and the host-side logic. Generalises data width and depth, adds a selectable full-policy (drop-new vs. overwrite-oldest), programmable almost-full/almost-empty thresholds, an occupancy count, a registered read-valid strobe, sticky overflow/underflow flags and a synchronous flush.

## Interface
- DATA_WIDTH, 8, bits per entry.
- ADDR_BITS, 4, depth = 2^ADDR_BITS entries; legal range 2..10.
- OVERWRITE, 0, full-policy: 0 = drop incoming write, 1 = overwrite oldest entry.
- AF_LEVEL, 2^ADDR_BITS-2, almost_full asserted when level >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when level <= AE_LEVEL.

- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- write_flag  in  1  write request, sampled each clock.
- data_in  in  DATA_WIDTH  write data.
- read_flag  in  1  read request, sampled each clock.
- flush  in  1  synchronous empty-the-FIFO command.
- clear_errors  in  1  synchronous clear of sticky error flags.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  one-cycle strobe: data_out updated by a successful read.
- empty_flag  out  1  level == 0.
- full_flag  out  1  level == 2^ADDR_BITS.
- almost_empty  out  1  level <= AE_LEVEL.
- almost_full  out  1  level >= AF_LEVEL.
- level  out  ADDR_BITS+1  current occupancy, 0..2^ADDR_BITS.
- overflow  out  1  sticky: a write found the FIFO full.
- underflow  out  1  sticky: a read found the FIFO empty.

## Operation
- Reset (reset_n low, async): read/write pointers 0, level 0, data_out 0, data_valid 0, overflow 0, underflow 0. Flags follow level: empty_flag 1, almost_empty 1, full_flag 0, almost_full 0.
- Pointers are ADDR_BITS wide, wrap naturally modulo depth. level is a separate ADDR_BITS+1 counter; flags decode combinationally from level only.
- Read, not empty: data_out <= mem[rd_ptr], rd_ptr+1, data_valid 1 next cycle. Read, empty: no state change except underflow <= 1; data_out holds, data_valid 0.
- Write, not full: mem[wr_ptr] <= data_in, wr_ptr+1.
- Write, full, no read: overflow <= 1 in both modes. OVERWRITE=0: data discarded, nothing else changes. OVERWRITE=1: write stored, wr_ptr+1, rd_ptr+1 (oldest lost), level unchanged.
- Read+write same cycle: not empty and not full -> both succeed, level unchanged. Full -> read returns oldest, write stored, level unchanged, no overflow. Empty -> read fails (underflow set), write stored, level 1; no fall-through.
- level update: +1 on write-only success, -1 on read-only success, unchanged otherwise.
- flush: pointers and level to 0 next cycle; any same-cycle read/write ignored; data_out holds; data_valid 0; error flags untouched.
- clear_errors: overflow/underflow <= 0, but an error event in the same cycle wins (flag reads 1).

## Timing
- Write-to-read latency: data written in cycle N readable by read_flag in cycle N+1; data_out/data_valid valid in cycle N+2.
- Read latency: one clock from read_flag to data_out/data_valid.
- Flags, level, error bits change only on clock edges (or async reset); no combinational input-to-output paths.
- Reset deasserted mid-operation: first edge after release behaves as from empty state; storage contents undefined and never observable.

## Structure
- Shared UART package/header: default DATA_WIDTH (8), default ADDR_BITS (4), depth function 2^ADDR_BITS.
- Sub-module uart_fifo_ram: DEPTH x DATA_WIDTH array, one synchronous write port, one registered read port; no reset on storage. Pointer, level, flag and error logic live in uart_sync_fifo.

## Test plan
- Reset then write 0x11..0x14 and read 4 -> data_out 0x11,0x12,0x13,0x14 each with one-cycle data_valid; level 4->0; empty_flag 1 at end.
- Defaults, OVERWRITE=0: write 17 values 0x00..0x10 -> full_flag after 16th, 0x10 dropped, overflow 1; reading 16 returns 0x00..0x0F.
- OVERWRITE=1: write 0x00..0x11 (18) -> level 16, overflow 1; reads return 0x02..0x11.
- Empty FIFO, read+write 0xA5 same cycle -> underflow 1, data_valid 0, level 1; next read returns 0xA5.
- Full FIFO, read+write same cycle for 20 cycles -> level stays 16, no overflow, ordering preserved across pointer wrap.
- Thresholds/flush/clear: fill to 14 -> almost_full 1; flush -> level 0, empty_flag 1; clear_errors coincident with empty read -> underflow stays 1; next-cycle clear -> 0.
